axi_bram_rd_arb: RTL and testbench
==================================

Name: axi_bram_rd_arb

Overview:
Round-robin read-channel arbiter that shares one AXI4 read port of the BRAM-backed AXI memory model among N_MASTER requesters. It grants one whole burst at a time from AR acceptance to the last R beat, and allows only one outstanding burst. It routes R beats back to the owning master and checks rlast against the burst length.

Parameters:
N_MASTER, 2, number of requesting masters (2..8)
ID_WIDTH, 4, AXI ID width per master
ADDR_WIDTH, 26, AXI address width (64MB)
DATA_WIDTH, 512, AXI data width

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset, synchronous, active-low
m_arvalid  in  N_MASTER  per-master AR valid
m_arready  out  N_MASTER  per-master AR ready
m_araddr  in  N_MASTER*ADDR_WIDTH  packed AR addresses, master k at slice k
m_arid  in  N_MASTER*ID_WIDTH  packed AR IDs
m_arlen  in  N_MASTER*8  packed burst lengths
m_arsize  in  N_MASTER*3  packed burst sizes
m_rvalid  out  N_MASTER  per-master R valid
m_rready  in  N_MASTER  per-master R ready
m_rdata  out  DATA_WIDTH  R data, broadcast to all masters
m_rid  out  ID_WIDTH  ID of the owning burst
m_rlast  out  1  last beat, generated from the beat counter
s_arvalid  out  1  to memory
s_arready  in  1  from memory
s_araddr  out  ADDR_WIDTH  to memory
s_arid  out  ID_WIDTH  to memory, the granted master's ID
s_arlen  out  8  to memory
s_arsize  out  3  to memory
s_rvalid  in  1  from memory
s_rready  out  1  to memory
s_rdata  in  DATA_WIDTH  from memory
s_rlast  in  1  from memory
err_rlast  out  1  sticky protocol error flag

Behaviour:
- Reset (s_axi_aresetn low at a clock edge):
  - state=IDLE, rr_ptr=0, beat counter=0, err_rlast=0.
  - All m_arready, m_rvalid, s_arvalid and s_rready are 0.
- Reset mid-burst abandons the burst. The memory shares the same reset.
- IDLE:
  - If any m_arvalid is set, pick the first set bit searching upward from rr_ptr and wrapping modulo N_MASTER.
  - Register it as grant g; next state is ADDR. No handshake occurs in IDLE.
- ADDR:
  - s_arvalid=m_arvalid[g]; s_araddr, s_arid, s_arlen and s_arsize are taken from slice g.
  - m_arready[g]=s_arready; all other m_arready bits are 0.
  - On s_arvalid&&s_arready: latch arid into rid_reg, load beat_cnt=arlen, go to DATA.
  - If m_arvalid[g] drops (illegal), stay in ADDR and keep waiting.
- DATA:
  - m_rvalid[g]=s_rvalid; all other m_rvalid bits are 0.
  - s_rready=m_rready[g]; m_rdata=s_rdata; m_rid=rid_reg; m_rlast=(beat_cnt==0).
  - Each beat handshake (s_rvalid&&s_rready) decrements beat_cnt while it is nonzero.
  - On the handshake with beat_cnt==0: go to IDLE, rr_ptr=(g+1) mod N_MASTER.
  - If s_rlast differs from (beat_cnt==0) on any handshake, set err_rlast. It clears only on reset.
  - The counter, not s_rlast, terminates the burst.
- Latency:
  - m_arvalid to s_arvalid: 1 cycle (the IDLE cycle).
  - AR and R paths are combinational pass-through once granted.
  - Back-to-back bursts have 1 idle cycle between the last R handshake and the next s_arvalid.
- Simultaneous requests: only the granted master sees arready. The others hold arvalid per AXI and wait.
- Fairness: a master whose request is pending is granted within N_MASTER-1 bursts.
- arlen=0: a single beat with m_rlast=1; legal.
- arlen=255: a 256-beat burst; beat_cnt is 8 bits and does not wrap.
- Sole requester: the same master is re-granted each burst, and rr_ptr still advances.

Test Plan:
1. M0 alone, araddr=0x1000, arlen=3 -> s_arvalid rises 1 cycle after m_arvalid. 4 beats reach M0 only; m_rlast on the 4th beat. m_rid=M0 arid.
2. M0 and M1 both request in the same cycle, rr_ptr=0 -> M0 is served first, then M1. With both requesting continuously, grants alternate 0,1,0,1 over 4 bursts.
3. m_rready[g] toggled 1,0,1,0 during an 8-beat burst -> s_rready follows it. No beats are lost or duplicated, and the data order matches the memory contents.
4. Memory asserts s_rlast on beat 2 of an arlen=3 burst -> err_rlast=1. The burst still runs 4 beats and m_rlast appears only on the 4th.
5. arlen=0 and arlen=255 bursts -> 1 beat and 256 beats respectively, each with a single m_rlast.
6. s_axi_aresetn held low for 1 cycle at beat 5 of a 16-beat burst -> the next cycle shows state=IDLE, all valid/ready outputs 0, rr_ptr=0, err_rlast=0.

Source files
------------

// File: rtl/axi_bram_rd_arb.sv
// Round-robin AXI4 read-channel arbiter: one burst in flight at a time, R beats
// routed back to the owning master and terminated by a local beat counter.
module axi_bram_rd_arb #(
  parameter int N_MASTER   = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  input  logic [N_MASTER-1:0]            m_arvalid,
  output logic [N_MASTER-1:0]            m_arready,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] m_araddr,
  input  logic [N_MASTER*ID_WIDTH-1:0]   m_arid,
  input  logic [N_MASTER*8-1:0]          m_arlen,
  input  logic [N_MASTER*3-1:0]          m_arsize,
  output logic [N_MASTER-1:0]            m_rvalid,
  input  logic [N_MASTER-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic [ID_WIDTH-1:0]            m_rid,
  output logic                           m_rlast,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  output logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic [ID_WIDTH-1:0]            s_arid,
  output logic [7:0]                     s_arlen,
  output logic [2:0]                     s_arsize,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic                           s_rlast,
  output logic                           err_rlast
);

  localparam int GW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_reg, state_next;
  logic [GW-1:0]       grant_reg, grant_next;
  logic [GW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [7:0]          beat_cnt_reg, beat_cnt_next;
  logic [ID_WIDTH-1:0] rid_reg, rid_next;
  logic                err_rlast_reg, err_rlast_next;

  logic [ADDR_WIDTH-1:0] araddr_arr [N_MASTER];
  logic [ID_WIDTH-1:0]   arid_arr   [N_MASTER];
  logic [7:0]            arlen_arr  [N_MASTER];
  logic [2:0]            arsize_arr [N_MASTER];

  generate
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_unpack
      assign araddr_arr[gi] = m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign arid_arr[gi]   = m_arid[gi*ID_WIDTH +: ID_WIDTH];
      assign arlen_arr[gi]  = m_arlen[gi*8 +: 8];
      assign arsize_arr[gi] = m_arsize[gi*3 +: 3];
    end
  endgenerate

  // Walk offsets from high to low so the smallest offset from rr_ptr wins.
  logic [GW-1:0] pick;
  int            idx;
  always_comb begin
    pick = rr_ptr_reg;
    idx  = 0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (m_arvalid[GW'(idx)]) pick = GW'(idx);
    end
  end

  assign s_araddr  = araddr_arr[grant_reg];
  assign s_arid    = arid_arr[grant_reg];
  assign s_arlen   = arlen_arr[grant_reg];
  assign s_arsize  = arsize_arr[grant_reg];
  assign m_rdata   = s_rdata;
  assign m_rid     = rid_reg;
  assign err_rlast = err_rlast_reg;

  logic ar_hs, r_hs, cnt_zero;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    rid_next       = rid_reg;
    err_rlast_next = err_rlast_reg;
    m_arready      = '0;
    m_rvalid       = '0;
    s_arvalid      = 1'b0;
    s_rready       = 1'b0;
    m_rlast        = 1'b0;
    cnt_zero       = (beat_cnt_reg == 8'd0);
    ar_hs          = 1'b0;
    r_hs           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|m_arvalid) begin
          grant_next = pick;
          state_next = ADDR;
        end
      end
      ADDR: begin
        s_arvalid            = m_arvalid[grant_reg];
        m_arready[grant_reg] = s_arready;
        ar_hs                = m_arvalid[grant_reg] && s_arready;
        if (ar_hs) begin
          rid_next      = arid_arr[grant_reg];
          beat_cnt_next = arlen_arr[grant_reg];
          state_next    = DATA;
        end
      end
      DATA: begin
        m_rvalid[grant_reg] = s_rvalid;
        s_rready            = m_rready[grant_reg];
        m_rlast             = cnt_zero;
        r_hs                = s_rvalid && m_rready[grant_reg];
        if (r_hs) begin
          // The memory's rlast is only audited; the counter ends the burst.
          if (s_rlast != cnt_zero) err_rlast_next = 1'b1;
          if (!cnt_zero) begin
            beat_cnt_next = beat_cnt_reg - 8'd1;
          end else begin
            state_next  = IDLE;
            rr_ptr_next = (grant_reg == GW'(N_MASTER - 1)) ? '0 : grant_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
      rid_reg       <= '0;
      err_rlast_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      rid_reg       <= rid_next;
      err_rlast_reg <= err_rlast_next;
    end
  end

endmodule

// File: tb/tb_axi_bram_rd_arb.sv
// Bench for axi_bram_rd_arb: table of burst scenarios, a mid-burst reset
// sequence and randomized traffic, all judged by a cycle-level reference model.
`timescale 1ns/1ps
module tb_axi_bram_rd_arb;
  localparam int N  = 3;
  localparam int IW = 4;
  localparam int AW = 26;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            s_axi_aresetn;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr;
  logic [N*IW-1:0] m_arid;
  logic [N*8-1:0]  m_arlen;
  logic [N*3-1:0]  m_arsize;
  logic [DW-1:0]   m_rdata, s_rdata;
  logic [IW-1:0]   m_rid, s_arid;
  logic            m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, err_rlast;
  logic [AW-1:0]   s_araddr;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize;

  always #5 clk = ~clk;

  axi_bram_rd_arb #(.N_MASTER(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .err_rlast(err_rlast)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
  } req_t;

  typedef struct {
    logic [N-1:0] mask;
    int           nburst;
    int           len;
    int           rr_mode;
    int           bad_beat;
    bit           mem_rand;
    int           exp_beats;
    int           exp_lasts;
    bit           exp_err;
    logic [31:0]  exp_order;
  } vec_t;

  // Environment: master request queues and the memory's accepted bursts.
  req_t mq [N][$];
  req_t sq[$];
  int   sbeat;
  int   rr_mode;
  int   bad_beat;
  bit   mem_rand;
  bit   tog;

  // Reference model: who owns the port, and how much of the burst remains.
  int   owner;
  bit   accepted;
  int   beats_left;
  int   beat_idx;
  int   ptr;
  bit   model_err;
  req_t cur;

  int   n_beats, n_lasts;
  int   grants[$];
  int   checks, errors;

  function automatic bit bitk(input logic [N-1:0] v, input int k);
    return |(v & (N'(1) << k));
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input int b);
    return {6'd0, a, 16'(b), 16'hC0DE};
  endfunction

  function automatic bit quiet();
    bit q;
    q = (owner < 0) && (sq.size() == 0);
    for (int k = 0; k < N; k++) if (mq[k].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst_now);
    logic [N-1:0] exp_arready, exp_rvalid;
    logic         exp_s_arvalid, exp_s_rready;
    bit           r_hs;
    req_t         r;
    @(negedge clk);
    tog = ~tog;
    s_axi_aresetn = ~rst_now;
    for (int k = 0; k < N; k++) begin
      if (!rst_now && mq[k].size() > 0) begin
        m_arvalid[k]         = 1'b1;
        m_araddr[k*AW +: AW] = mq[k][0].addr;
        m_arid[k*IW +: IW]   = mq[k][0].id;
        m_arlen[k*8 +: 8]    = mq[k][0].len;
        m_arsize[k*3 +: 3]   = 3'd3;
      end else begin
        m_arvalid[k] = 1'b0;
      end
      case (rr_mode)
        0:       m_rready[k] = 1'b1;
        1:       m_rready[k] = tog;
        default: m_rready[k] = 1'($urandom_range(0, 1));
      endcase
    end
    s_arready = rst_now ? 1'b0 : (mem_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (!rst_now && sq.size() > 0) begin
      s_rvalid = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      s_rdata  = mem_word(sq[0].addr, sbeat);
      s_rlast  = (sbeat == int'(sq[0].len)) ^ (sbeat == bad_beat);
    end else begin
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      s_rdata  = '0;
    end
    #1;
    if (rst_now) begin
      owner = -1; accepted = 0; ptr = 0; model_err = 0; sbeat = 0;
      for (int k = 0; k < N; k++) mq[k].delete();
      sq.delete();
      return;
    end

    exp_arready = '0; exp_rvalid = '0; exp_s_arvalid = 1'b0; exp_s_rready = 1'b0;
    if (owner >= 0 && !accepted) begin
      exp_s_arvalid = bitk(m_arvalid, owner);
      exp_arready   = N'(s_arready) << owner;
    end
    if (owner >= 0 && accepted) begin
      exp_rvalid   = N'(s_rvalid) << owner;
      exp_s_rready = bitk(m_rready, owner);
    end
    chk("m_arready", 64'(m_arready), 64'(exp_arready));
    chk("m_rvalid", 64'(m_rvalid), 64'(exp_rvalid));
    chk("s_arvalid", 64'(s_arvalid), 64'(exp_s_arvalid));
    chk("s_rready", 64'(s_rready), 64'(exp_s_rready));
    chk("err_rlast", 64'(err_rlast), 64'(model_err));
    if (exp_s_arvalid && mq[owner].size() > 0) begin
      chk("s_araddr", 64'(s_araddr), 64'(mq[owner][0].addr));
      chk("s_arid", 64'(s_arid), 64'(mq[owner][0].id));
      chk("s_arlen", 64'(s_arlen), 64'(mq[owner][0].len));
      chk("s_arsize", 64'(s_arsize), 64'd3);
    end
    r_hs = (owner >= 0) && accepted && s_rvalid && bitk(m_rready, owner);
    if (r_hs) begin
      chk("m_rdata", 64'(m_rdata), 64'(mem_word(cur.addr, beat_idx)));
      chk("m_rid", 64'(m_rid), 64'(cur.id));
      chk("m_rlast", 64'(m_rlast), 64'(beats_left == 1));
    end
    if (|(m_rvalid & m_rready)) begin
      n_beats++;
      if (m_rlast) n_lasts++;
    end

    // Advance the model to the state after the coming clock edge.
    if (owner < 0) begin
      if (|m_arvalid) begin
        for (int i = N - 1; i >= 0; i--) if (bitk(m_arvalid, (ptr + i) % N)) owner = (ptr + i) % N;
        accepted = 0;
      end
    end else if (!accepted) begin
      if (bitk(m_arvalid, owner) && s_arready && mq[owner].size() > 0) begin
        cur = mq[owner][0];
        accepted = 1;
        beats_left = int'(cur.len) + 1;
        beat_idx = 0;
        grants.push_back(owner);
      end
    end else if (r_hs) begin
      if (s_rlast != (beats_left == 1)) model_err = 1;
      beat_idx++;
      beats_left--;
      if (beats_left == 0) begin
        $display("burst: master %0d addr %h id %h beats %0d", owner, cur.addr, cur.id, beat_idx);
        ptr = (owner + 1) % N;
        owner = -1;
        accepted = 0;
      end
    end

    for (int k = 0; k < N; k++)
      if (bitk(m_arvalid & m_arready, k) && mq[k].size() > 0) void'(mq[k].pop_front());
    if (s_rvalid && s_rready && sq.size() > 0) begin
      if (sbeat == int'(sq[0].len)) begin
        void'(sq.pop_front());
        sbeat = 0;
      end else begin
        sbeat++;
      end
    end
    if (s_arvalid && s_arready) begin
      r.addr = s_araddr; r.id = s_arid; r.len = s_arlen;
      sq.push_back(r);
    end
  endtask

  task automatic run_scenario(input int budget, input string tag);
    int n;
    n = 0;
    while (!quiet() && n < budget) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (!quiet()) begin
      errors++;
      $display("FAIL %s timeout: still busy after %0d cycles, expected idle", tag, n);
    end
  endtask

  // Drives every input so a wrongly live FSM would show a valid or ready.
  task automatic post_reset_check();
    @(negedge clk);
    s_axi_aresetn = 1'b1;
    m_arvalid = '0; m_rready = '1; s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    chk("rst m_arready", 64'(m_arready), 64'd0);
    chk("rst m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst s_rready", 64'(s_rready), 64'd0);
    chk("rst err_rlast", 64'(err_rlast), 64'd0);
  endtask

  task automatic push_req(input int k, input int j, input int len);
    req_t r;
    r.addr = AW'(32'h1000 + k * 32'h10000 + j * 32'h400);
    r.id   = IW'(k * 4 + j);
    r.len  = 8'(len);
    mq[k].push_back(r);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] order;
    int          n;
    checks = 0; errors = 0; tog = 0; sbeat = 0;
    owner = -1; accepted = 0; ptr = 0; model_err = 0; beats_left = 0; beat_idx = 0;
    rr_mode = 0; bad_beat = -1; mem_rand = 0;
    s_axi_aresetn = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_rready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;

    vecs[0] = '{mask:3'b001, nburst:1, len:3,   rr_mode:0, bad_beat:-1, mem_rand:0, exp_beats:4,   exp_lasts:1, exp_err:0, exp_order:32'h0};
    vecs[1] = '{mask:3'b011, nburst:2, len:1,   rr_mode:0, bad_beat:-1, mem_rand:0, exp_beats:8,   exp_lasts:4, exp_err:0, exp_order:32'h0101};
    vecs[2] = '{mask:3'b010, nburst:1, len:7,   rr_mode:1, bad_beat:-1, mem_rand:0, exp_beats:8,   exp_lasts:1, exp_err:0, exp_order:32'h1};
    vecs[3] = '{mask:3'b001, nburst:1, len:3,   rr_mode:0, bad_beat:1,  mem_rand:0, exp_beats:4,   exp_lasts:1, exp_err:1, exp_order:32'h0};
    vecs[4] = '{mask:3'b100, nburst:2, len:0,   rr_mode:0, bad_beat:-1, mem_rand:1, exp_beats:2,   exp_lasts:2, exp_err:0, exp_order:32'h22};
    vecs[5] = '{mask:3'b001, nburst:1, len:255, rr_mode:2, bad_beat:-1, mem_rand:1, exp_beats:256, exp_lasts:1, exp_err:0, exp_order:32'h0};
    vecs[6] = '{mask:3'b111, nburst:2, len:2,   rr_mode:2, bad_beat:-1, mem_rand:1, exp_beats:18,  exp_lasts:6, exp_err:0, exp_order:32'h012012};
    vecs[7] = '{mask:3'b110, nburst:1, len:5,   rr_mode:0, bad_beat:-1, mem_rand:0, exp_beats:12,  exp_lasts:2, exp_err:0, exp_order:32'h12};

    cycle(1'b1);
    cycle(1'b1);
    post_reset_check();

    for (int v = 0; v < 8; v++) begin
      cycle(1'b1);
      rr_mode = vecs[v].rr_mode; bad_beat = vecs[v].bad_beat; mem_rand = vecs[v].mem_rand;
      n_beats = 0; n_lasts = 0; grants.delete();
      for (int j = 0; j < vecs[v].nburst; j++)
        for (int k = 0; k < N; k++)
          if (bitk(vecs[v].mask, k)) push_req(k, j, vecs[v].len);
      run_scenario(3000, "table");
      order = '0;
      foreach (grants[i]) order = (order << 4) | 32'(grants[i]);
      chk("vec beats", 64'(n_beats), 64'(vecs[v].exp_beats));
      chk("vec rlasts", 64'(n_lasts), 64'(vecs[v].exp_lasts));
      chk("vec grants", 64'(grants.size()), 64'(vecs[v].exp_lasts));
      chk("vec order", 64'(order), 64'(vecs[v].exp_order));
      chk("vec err_rlast", 64'(err_rlast), 64'(vecs[v].exp_err));
      $display("vector %0d: beats %0d rlasts %0d order %h err %0d", v, n_beats, n_lasts, order, err_rlast);
    end

    // Bad rlast sets the flag, then a reset in the middle of a 16-beat burst
    // must clear it and restart the round-robin pointer at master 0.
    cycle(1'b1);
    rr_mode = 0; mem_rand = 0; bad_beat = 1;
    push_req(0, 0, 3);
    run_scenario(200, "rlast err");
    chk("err before reset", 64'(err_rlast), 64'd1);
    bad_beat = -1;
    push_req(1, 0, 15);
    n = 0;
    while (!(owner == 1 && accepted && beat_idx == 5) && n < 200) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (!(owner == 1 && accepted && beat_idx == 5)) begin
      errors++;
      $display("FAIL reach beat 5: got beat %0d after %0d cycles, expected beat 5", beat_idx, n);
    end
    cycle(1'b1);
    post_reset_check();
    grants.delete();
    push_req(1, 1, 0);
    push_req(0, 1, 0);
    run_scenario(200, "post reset");
    chk("post reset first grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
    $display("mid-burst reset: first grant after reset %0d", grants.size() > 0 ? grants[0] : -1);

    cycle(1'b1);
    rr_mode = 2; mem_rand = 1; bad_beat = -1; grants.delete();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, N - 1);
        if (mq[n].size() < 3) push_req(n, $urandom_range(0, 3), $urandom_range(0, 15));
      end
      cycle(1'b0);
    end
    run_scenario(3000, "random drain");
    chk("random err_rlast", 64'(err_rlast), 64'd0);
    $display("random phase: %0d bursts", grants.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
